// File: rtl/vendo_pkg.sv
// ============================================================================
// Module      : vendo_pkg
// Description : Shared constants for the vending input conditioner. Channel
//               indices double as arbiter priority (lower index wins). Also
//               provides the saturating coin accumulator helper.
// Macro       : VENDO_COIN_TOTAL_EN (enables the coin total in the top level)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vendo_pkg;

   localparam int NUM_CH  = 4;

   // Channel indices, ordered by arbiter priority (0 = highest)
   localparam int CH_P5   = 0;
   localparam int CH_P1   = 1;
   localparam int CH_SELA = 2;
   localparam int CH_SELB = 3;

   localparam logic [7:0] COIN_P1        = 8'd1;
   localparam logic [7:0] COIN_P5        = 8'd5;
   localparam logic [7:0] COIN_TOTAL_MAX = 8'd255;

   typedef logic [NUM_CH-1:0] ch_vec_t;

   // Add a coin value to the running total, clamping at COIN_TOTAL_MAX
   function automatic logic [7:0] coin_sat_add(input logic [7:0] total,
                                                input logic [7:0] amount);
      logic [8:0] sum;
      sum = {1'b0, total} + {1'b0, amount};
      return (sum > {1'b0, COIN_TOTAL_MAX}) ? COIN_TOTAL_MAX : sum[7:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/vendo_debounce.sv
// ============================================================================
// Module      : vendo_debounce
// Description : One input channel: two-flop synchroniser, debounce counter,
//               accepted ("stable") level and rising-edge detect.
// Ports       : clk  in  1 - system clock
//               rst  in  1 - asynchronous active-high reset
//               raw  in  1 - asynchronous, possibly bouncing input
//               rise out 1 - high for one cycle after stable goes 0->1
// Parameters  : DEBOUNCE_CYCLES - stable samples needed (1..255)
//               CNT_W           - counter width, 2**CNT_W > DEBOUNCE_CYCLES
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vendo_debounce
   import vendo_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             r_sync1;
   logic             r_s;
   logic             r_stable;
   logic             r_stable_d;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1    <= 1'b0;
         r_s        <= 1'b0;
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_sync1    <= raw;
         r_s        <= r_sync1;
         r_stable_d <= r_stable;
         if (r_s == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            // This sample is the DEBOUNCE_CYCLES-th consecutive difference
            r_stable <= r_s;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end
   end

   // Edge detect on the registered level keeps pending one stage behind stable
   assign rise = r_stable & ~r_stable_d;

endmodule

`default_nettype wire

// File: rtl/vendo_input_cond.sv
// ============================================================================
// Module      : vendo_input_cond
// Description : Input conditioner for the vending FSM. Debounces four raw
//               inputs, latches each accepted press as a pending flag and
//               issues at most one registered strobe per cycle using fixed
//               priority p_5 > p_1 > sel_A > sel_B.
// Ports       : clk        in  1 - system clock
//               rst        in  1 - asynchronous active-high reset
//               raw_sel_A  in  1 - item A button (raw)
//               raw_sel_B  in  1 - item B button (raw)
//               raw_p_1    in  1 - 1-peso coin sensor (raw)
//               raw_p_5    in  1 - 5-peso coin sensor (raw)
//               sel_A      out 1 - one-cycle strobe
//               sel_B      out 1 - one-cycle strobe
//               p_1        out 1 - one-cycle strobe
//               p_5        out 1 - one-cycle strobe
//               coin_total out 8 - saturating coin sum (VENDO_COIN_TOTAL_EN)
// Macro       : VENDO_COIN_TOTAL_EN - adds the coin_total port and register
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vendo_input_cond
   import vendo_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_sel_A,
   input  logic       raw_sel_B,
   input  logic       raw_p_1,
   input  logic       raw_p_5,
   output logic       sel_A,
   output logic       sel_B,
   output logic       p_1,
   output logic       p_5
`ifdef VENDO_COIN_TOTAL_EN
   ,
   output logic [7:0] coin_total
`endif
);

   ch_vec_t w_raw;
   ch_vec_t w_rise;
   ch_vec_t w_grant;
   logic    w_found;
   ch_vec_t r_pending;
   ch_vec_t r_strobe;

   assign w_raw[CH_P5]   = raw_p_5;
   assign w_raw[CH_P1]   = raw_p_1;
   assign w_raw[CH_SELA] = raw_sel_A;
   assign w_raw[CH_SELB] = raw_sel_B;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      vendo_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce (
         .clk  (clk),
         .rst  (rst),
         .raw  (w_raw[g]),
         .rise (w_rise[g])
      );
   end

   // Lowest set index wins, so the grant is one-hot or zero by construction
   always_comb begin
      w_grant = '0;
      w_found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_pending[i] && !w_found) begin
            w_grant[i] = 1'b1;
            w_found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
         r_strobe  <= '0;
      end else begin
         // A fresh rise on the granted channel survives the clear (OR last);
         // a rise on an already-pending channel coalesces into it
         r_pending <= (r_pending & ~w_grant) | w_rise;
         r_strobe  <= w_grant;
      end
   end

   assign p_5   = r_strobe[CH_P5];
   assign p_1   = r_strobe[CH_P1];
   assign sel_A = r_strobe[CH_SELA];
   assign sel_B = r_strobe[CH_SELB];

`ifdef VENDO_COIN_TOTAL_EN
   logic [7:0] r_total;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_total <= '0;
      end else if (w_grant[CH_P5]) begin
         r_total <= coin_sat_add(r_total, COIN_P5);
      end else if (w_grant[CH_P1]) begin
         r_total <= coin_sat_add(r_total, COIN_P1);
      end
   end

   assign coin_total = r_total;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vendo_input_cond.sv
// ============================================================================
// Module      : tb_vendo_input_cond
// Description : Self-checking bench for vendo_input_cond. A history-based
//               reference model predicts the strobes (and coin total when
//               VENDO_COIN_TOTAL_EN is defined) every cycle; directed
//               scenarios add hand-computed timing and count expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vendo_input_cond;
   import vendo_pkg::*;

   localparam int DB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic raw_sel_A = 1'b0;
   logic raw_sel_B = 1'b0;
   logic raw_p_1   = 1'b0;
   logic raw_p_5   = 1'b0;
   logic sel_A, sel_B, p_1, p_5;
`ifdef VENDO_COIN_TOTAL_EN
   logic [7:0] coin_total;
`endif

   always #5 clk = ~clk;

   vendo_input_cond #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .raw_sel_A (raw_sel_A),
      .raw_sel_B (raw_sel_B),
      .raw_p_1   (raw_p_1),
      .raw_p_5   (raw_p_5),
      .sel_A     (sel_A),
      .sel_B     (sel_B),
      .p_1       (p_1),
      .p_5       (p_5)
`ifdef VENDO_COIN_TOTAL_EN
      ,
      .coin_total(coin_total)
`endif
   );

   int n_total = 0;
   int n_bad   = 0;
   int edge_n  = 0;

   // Reference model state: raw history per channel, accepted level,
   // presses waiting to be issued
   logic [1:0]  m_pipe   [NUM_CH];
   logic [31:0] m_hist   [NUM_CH];
   logic        m_stable [NUM_CH];
   logic [3:0]  m_rose;
   logic [3:0]  m_pend;
   logic [3:0]  m_exp;
   int          m_total;

   // Observed strobe statistics for the directed checks
   int st_cnt   [NUM_CH];
   int st_first [NUM_CH];

   task automatic check(input string name, input int got, input int want);
      n_total++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (edge %0d)", name, got, want, edge_n);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_pipe[c]   = '0;
         m_hist[c]   = '0;
         m_stable[c] = 1'b0;
      end
      m_rose  = '0;
      m_pend  = '0;
      m_exp   = '0;
      m_total = 0;
   endtask

   // One rising edge: the accepted level flips once the last DB synchronised
   // samples all disagree with it; a new press becomes pending one edge after
   // it is accepted and is issued the edge after that if nobody outranks it.
   task automatic model_step(input logic [3:0] raw);
      logic [31:0] mask;
      logic [3:0]  grant;
      logic        s;
      mask  = (32'd1 << DB) - 32'd1;
      grant = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (m_pend[c] && grant == 4'd0) grant[c] = 1'b1;
      m_pend = (m_pend & ~grant) | m_rose;
      m_exp  = grant;
      if (grant[CH_P5]) m_total = (m_total + 5 > 255) ? 255 : m_total + 5;
      if (grant[CH_P1]) m_total = (m_total + 1 > 255) ? 255 : m_total + 1;
      for (int c = 0; c < NUM_CH; c++) begin
         s            = m_pipe[c][1];
         m_pipe[c][1] = m_pipe[c][0];
         m_pipe[c][0] = raw[c];
         m_hist[c]    = {m_hist[c][30:0], s};
         m_rose[c]    = 1'b0;
         if (!m_stable[c] && (m_hist[c] & mask) == mask) begin
            m_stable[c] = 1'b1;
            m_rose[c]   = 1'b1;
         end else if (m_stable[c] && (m_hist[c] & mask) == 32'd0) begin
            m_stable[c] = 1'b0;
         end
      end
   endtask

   task automatic compare();
      logic [3:0] dut_v;
      dut_v[CH_P5]   = p_5;
      dut_v[CH_P1]   = p_1;
      dut_v[CH_SELA] = sel_A;
      dut_v[CH_SELB] = sel_B;
      check("strobes", int'(dut_v), int'(m_exp));
`ifdef VENDO_COIN_TOTAL_EN
      check("coin_total", int'(coin_total), m_total);
`endif
      for (int c = 0; c < NUM_CH; c++) begin
         if (dut_v[c]) begin
            st_cnt[c]++;
            if (st_first[c] < 0) st_first[c] = edge_n;
         end
      end
   endtask

   task automatic clr_stats();
      for (int c = 0; c < NUM_CH; c++) begin
         st_cnt[c]   = 0;
         st_first[c] = -1;
      end
   endtask

   // Called at a negedge: drive raw, take one posedge, check, return at next negedge
   task automatic cycle(input logic [3:0] raw);
      raw_p_5   = raw[CH_P5];
      raw_p_1   = raw[CH_P1];
      raw_sel_A = raw[CH_SELA];
      raw_sel_B = raw[CH_SELB];
      @(posedge clk);
      edge_n++;
      if (rst) model_reset();
      else     model_step(raw);
      #1;
      compare();
      @(negedge clk);
   endtask

   task automatic pulse_reset(input logic [3:0] raw, input int n);
      rst = 1'b1;
      model_reset();
      #1;
      compare();
      check("rst_outs", int'({sel_B, sel_A, p_1, p_5}), 0);
      repeat (n) cycle(raw);
      rst = 1'b0;
   endtask

   task automatic press(input int ch, input int hi, input int lo);
      logic [3:0] r;
      r     = '0;
      r[ch] = 1'b1;
      repeat (hi) cycle(r);
      repeat (lo) cycle(4'b0000);
   endtask

   initial begin
      int e0;
      logic [3:0] r;
      int hold [NUM_CH];
      logic [3:0] lvl;

      clr_stats();
      model_reset();
      @(negedge clk);
      #1;
      check("reset_state", int'({sel_B, sel_A, p_1, p_5}), 0);
      compare();
      repeat (2) cycle(4'b0000);
      rst = 1'b0;
      repeat (3) cycle(4'b0000);

      // Clean p_1 press held 30 cycles
      clr_stats();
      e0 = edge_n + 1;
      press(CH_P1, 30, 10);
      check("p1_count", st_cnt[CH_P1], 1);
      check("p1_latency", st_first[CH_P1] - e0, 7);
      check("p1_others", st_cnt[CH_P5] + st_cnt[CH_SELA] + st_cnt[CH_SELB], 0);

      // sel_A bouncing every cycle, then steady high
      clr_stats();
      for (int i = 0; i < 10; i++) cycle((i % 2 == 0) ? 4'b0100 : 4'b0000);
      press(CH_SELA, 20, 10);
      check("bounce_selA", st_cnt[CH_SELA], 1);

      // 3-cycle glitch alone
      clr_stats();
      press(CH_SELA, 3, 15);
      check("glitch_selA", st_cnt[CH_SELA], 0);

      // Simultaneous p_5, p_1, sel_B
      clr_stats();
      e0 = edge_n + 1;
      r  = '0;
      r[CH_P5] = 1'b1; r[CH_P1] = 1'b1; r[CH_SELB] = 1'b1;
      repeat (20) cycle(r);
      repeat (10) cycle(4'b0000);
      check("simul_p5_edge", st_first[CH_P5] - e0, 7);
      check("simul_p1_edge", st_first[CH_P1] - e0, 8);
      check("simul_selB_edge", st_first[CH_SELB] - e0, 9);
      check("simul_counts", st_cnt[CH_P5] + st_cnt[CH_P1] + st_cnt[CH_SELB], 3);

      // Reset midway through a sel_B debounce, input held through and after
      r = '0;
      r[CH_SELB] = 1'b1;
      repeat (3) cycle(r);
      pulse_reset(r, 2);
      clr_stats();
      e0 = edge_n + 1;
      repeat (15) cycle(r);
      repeat (10) cycle(4'b0000);
      check("rst_selB_count", st_cnt[CH_SELB], 1);
      check("rst_selB_latency", st_first[CH_SELB] - e0, 7);

      // Press, release 5 cycles, re-press
      clr_stats();
      press(CH_P5, 15, 5);
      press(CH_P5, 15, 10);
      check("repress_p5", st_cnt[CH_P5], 2);

`ifdef VENDO_COIN_TOTAL_EN
      pulse_reset(4'b0000, 2);
      for (int i = 0; i < 3; i++) press(CH_P1, 12, 8);
      for (int i = 0; i < 2; i++) press(CH_P5, 12, 8);
      check("coin_13", int'(coin_total), 13);
      for (int i = 0; i < 60; i++) press(CH_P5, 10, 8);
      check("coin_sat", int'(coin_total), 255);
      pulse_reset(4'b0000, 1);
      check("coin_rst", int'(coin_total), 0);
      repeat (2) cycle(4'b0000);
`endif

      // Randomised levels with random hold lengths and occasional resets
      lvl = '0;
      for (int c = 0; c < NUM_CH; c++) hold[c] = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (hold[c] == 0) begin
               lvl[c]  = ~lvl[c];
               hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(4, 14));
            end
            hold[c]--;
         end
         if ($urandom_range(0, 299) == 0) pulse_reset(lvl, int'($urandom_range(1, 3)));
         cycle(lvl);
      end
      repeat (20) cycle(4'b0000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vendo_input_cond.md
# vendo_input_cond

Input conditioner feeding the vending FSM `top_vendo`. It takes the raw, asynchronous, bouncing selector buttons and coin sensors and synchronises and debounces them. It then delivers clean single-cycle strobes on `sel_A`, `sel_B`, `p_1` and `p_5`, at most one per cycle, so the FSM never sees a held, bouncing or simultaneous input.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required to accept a level change; legal range 1..255.
- `CNT_W`, default 8: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

One clock; reset is asynchronous and active-high.
- `clk`  in  1: system clock, shared with `top_vendo`.
- `rst`  in  1: asynchronous active-high reset.
- `raw_sel_A`  in  1: item A button, asynchronous, active-high, may bounce.
- `raw_sel_B`  in  1: item B button, asynchronous, active-high, may bounce.
- `raw_p_1`  in  1: 1-peso coin sensor, asynchronous, active-high, may bounce.
- `raw_p_5`  in  1: 5-peso coin sensor, asynchronous, active-high, may bounce.
- `sel_A`  out  1: one-cycle strobe to the FSM.
- `sel_B`  out  1: one-cycle strobe to the FSM.
- `p_1`  out  1: one-cycle strobe to the FSM.
- `p_5`  out  1: one-cycle strobe to the FSM.
- `coin_total`  out  8: accepted coin value; present only with the macro in Configuration.

## Operation
Per channel:
- Two-flop synchroniser produces `s`.
- `stable` register holds the accepted level; it resets to 0.
- Counter is cleared whenever `s == stable`.
- Counter increments while `s != stable`.
- `stable` takes `s` on the edge where `s` has differed for `DEBOUNCE_CYCLES` consecutive samples; the counter clears on the same edge.
- A 0->1 transition of `stable` sets the channel's `pending` flag; 1->0 transitions are ignored.
- Holding an input produces exactly one strobe; release and re-press produces another.
- A rising `stable` while `pending` is already set is coalesced: no second strobe.

Arbiter:
- Fixed priority: `p_5` > `p_1` > `sel_A` > `sel_B`.
- Each cycle, the highest-priority set `pending` is issued as a registered strobe and cleared.
- A channel whose `pending` sets on the same edge its strobe issues keeps the new flag.
- All four outputs are one-hot or zero in every cycle.
- Lower-priority pending flags wait; none are lost except by coalescing.

Reset:
- All outputs are 0 during reset.
- Synchronisers, `stable`, counters, `pending` and `coin_total` clear immediately.
- An input already high when `rst` deasserts produces one strobe after the normal debounce latency; it is treated as a fresh press.

## Timing
- Latency: edge 0 is the first rising `clk` that samples a clean raw input high. With no contention, the strobe is high for the cycle following edge `DEBOUNCE_CYCLES`+3:
  - `s` is high after edge 1.
  - `stable` is high after edge `DEBOUNCE_CYCLES`+1.
  - `pending` is set after edge `DEBOUNCE_CYCLES`+2.
  - The output is registered at edge `DEBOUNCE_CYCLES`+3.
- Each lost arbitration adds one cycle.
- Strobe width is always exactly 1 cycle.
- A glitch that keeps `s` high for fewer than `DEBOUNCE_CYCLES` consecutive samples produces no strobe.
- Release detection also needs `DEBOUNCE_CYCLES` low samples before a new press can register.

## Configuration
- `VENDO_COIN_TOTAL_EN` defined:
  - `coin_total` port exists.
  - Adds 1 on each issued `p_1` strobe and 5 on each issued `p_5` strobe.
  - Saturates at 255 with no wrap.
  - Updates on the same edge as the strobe is registered.
  - Cleared only by `rst`.
- Macro undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- Package `vendo_pkg`:
  - Channel index constants: `CH_P5`=0, `CH_P1`=1, `CH_SELA`=2, `CH_SELB`=3, which also encode arbiter priority.
  - `NUM_CH`=4.
  - Coin values `COIN_P1`=1, `COIN_P5`=5.
  - `COIN_TOTAL_MAX`=255.
- Sub-module `vendo_debounce`: synchroniser, counter, `stable` and rising-edge detect, outputting `rise`. Instantiated four times.
- Top level holds the pending flags, arbiter, output registers and optional total.

## Test plan
All with `DEBOUNCE_CYCLES`=4.
- Clean `raw_p_1` press held 30 cycles -> `p_1` high for exactly one cycle, 7 cycles after the first sampling edge; other outputs stay 0.
- `raw_sel_A` bouncing 1/0 every cycle for 10 cycles, then steady high -> exactly one `sel_A` strobe. A 3-cycle glitch alone -> no strobe.
- `raw_p_5`, `raw_p_1` and `raw_sel_B` rising on the same edge -> `p_5`, `p_1`, `sel_B` strobes on three consecutive cycles, never overlapping.
- `rst` asserted midway through a `raw_sel_B` debounce (edge 3) -> all outputs 0 immediately. After release with the input held, one `sel_B` strobe 7 cycles after reset deassertion.
- Press, release for 5 cycles, re-press `raw_p_5` -> two `p_5` strobes.
- `VENDO_COIN_TOTAL_EN` defined:
  - 3 `p_1` and 2 `p_5` presses -> `coin_total` = 13.
  - 60 `p_5` presses -> `coin_total` = 255 (saturated).
  - Then `rst` -> `coin_total` = 0.
